// File: rtl/cfg_frame_loader_pkg.sv
// Shared types and constants for the configuration frame loader.
package cfg_frame_loader_pkg;

    typedef enum logic [2:0] {
        SYNC   = 3'd0,
        ADDR   = 3'd1,
        DATA   = 3'd2,
        CSUM   = 3'd3,
        COMMIT = 3'd4,
        ERROR  = 3'd5
    } cfg_state_t;

    localparam int FRAME_DATA_BYTES = 5;
    localparam int WORD_W = 8 * FRAME_DATA_BYTES;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // True when any bit at or above prog_w is set in the assembled word.
    function automatic logic pad_bits_set(input logic [WORD_W-1:0] word, input int prog_w);
        logic [WORD_W-1:0] keep;
        keep = (WORD_W'(1) << prog_w) - WORD_W'(1);
        return |(word & ~keep);
    endfunction

endpackage

// File: rtl/cfg_frame_loader_if.sv
// Byte stream in, tile config write out.
interface cfg_frame_loader_if #(
    parameter int ADDR_W = 4,
    parameter int PROG_W = 34
);
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [PROG_W-1:0] prog_data;

    // Bitstream source / tile side
    modport master (
        output s_data, s_valid,
        input  s_ready, prog_we, prog_addr, prog_data
    );

    // Loader side
    modport slave (
        input  s_data, s_valid,
        output s_ready, prog_we, prog_addr, prog_data
    );
endinterface

// File: rtl/cfg_frame_loader_assembler.sv
// Collects the data bytes of a frame little-endian into a 40-bit word and
// keeps the running XOR over ADDR and data bytes.
module cfg_frame_loader_assembler
    import cfg_frame_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              take_addr,
    input  logic              take_data,
    input  logic [7:0]        din,
    output logic [WORD_W-1:0] word,
    output logic [7:0]        csum,
    output logic              last
);
    logic [2:0] idx_r;

    // Shift register, byte index and running checksum
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word  <= '0;
            csum  <= 8'h00;
            idx_r <= 3'd0;
        end else if (take_addr) begin
            csum <= csum ^ din;
        end else if (take_data) begin
            word  <= {din, word[WORD_W-1:8]};
            csum  <= csum ^ din;
            idx_r <= idx_r + 3'd1;
        end else begin
            word  <= word;
            csum  <= csum;
            idx_r <= idx_r;
        end
    end

    assign last = (idx_r == 3'(FRAME_DATA_BYTES - 1));

endmodule

// File: rtl/cfg_frame_loader.sv
// Frame parser/validator issuing single-cycle config word writes to tiles.
module cfg_frame_loader
    import cfg_frame_loader_pkg::*;
#(
    parameter int         PROG_W    = 34,
    parameter int         NUM_TILES = 16,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic                 prog_clk,
    input  logic                 prog_res,
    cfg_frame_loader_if.slave    bus,
    output logic                 busy,
    output logic                 err_pulse,
    output logic [7:0]           err_cnt,
    output logic [15:0]          frame_cnt
);
    localparam int ADDR_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

    cfg_state_t        state_r;
    logic              s_ready_r;
    logic              prog_we_r;
    logic [ADDR_W-1:0] prog_addr_r;
    logic [PROG_W-1:0] prog_data_r;
    logic [7:0]        addr_r;

    logic              xfer_s;
    logic [WORD_W-1:0] word_s;
    logic [7:0]        csum_s;
    logic              last_s;
    logic              bad_s;

    assign xfer_s = bus.s_valid & s_ready_r;

    cfg_frame_loader_assembler u_asm (
        .clk       (prog_clk),
        .rst       (prog_res),
        .clear     ((state_r == SYNC) && xfer_s && (bus.s_data == SYNC_BYTE)),
        .take_addr ((state_r == ADDR) && xfer_s),
        .take_data ((state_r == DATA) && xfer_s),
        .din       (bus.s_data),
        .word      (word_s),
        .csum      (csum_s),
        .last      (last_s)
    );

    // Frame validity evaluated against the checksum byte on the bus
    always_comb begin
        bad_s = 1'b0;
        if (({1'b0, addr_r} >= 9'(NUM_TILES)) || pad_bits_set(word_s, PROG_W) ||
            (csum_s != bus.s_data)) begin
            bad_s = 1'b1;
        end else begin
            bad_s = 1'b0;
        end
    end

    // Frame FSM with registered handshake, write strobe and counters
    always_ff @(posedge prog_clk) begin
        if (prog_res) begin
            state_r     <= SYNC;
            s_ready_r   <= 1'b1;
            prog_we_r   <= 1'b0;
            prog_addr_r <= '0;
            prog_data_r <= '0;
            addr_r      <= 8'h00;
            busy        <= 1'b0;
            err_pulse   <= 1'b0;
            err_cnt     <= 8'h00;
            frame_cnt   <= 16'h0000;
        end else begin
            prog_we_r <= 1'b0;
            err_pulse <= 1'b0;
            case (state_r)
                SYNC: begin
                    if (xfer_s && (bus.s_data == SYNC_BYTE)) begin
                        state_r <= ADDR;
                        busy    <= 1'b1;
                    end
                end
                ADDR: begin
                    if (xfer_s) begin
                        addr_r  <= bus.s_data;
                        state_r <= DATA;
                    end
                end
                DATA: begin
                    if (xfer_s && last_s) begin
                        state_r <= CSUM;
                    end
                end
                CSUM: begin
                    if (xfer_s) begin
                        s_ready_r <= 1'b0;
                        if (bad_s) begin
                            state_r   <= ERROR;
                            err_pulse <= 1'b1;
                            if (err_cnt != 8'hFF) begin
                                err_cnt <= err_cnt + 8'd1;
                            end
                        end else begin
                            state_r     <= COMMIT;
                            prog_we_r   <= 1'b1;
                            prog_addr_r <= addr_r[ADDR_W-1:0];
                            prog_data_r <= word_s[PROG_W-1:0];
                            frame_cnt   <= frame_cnt + 16'd1;
                        end
                    end
                end
                COMMIT, ERROR: begin
                    state_r   <= SYNC;
                    s_ready_r <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state_r   <= SYNC;
                    s_ready_r <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready   = s_ready_r;
    assign bus.prog_we   = prog_we_r;
    assign bus.prog_addr = prog_addr_r;
    assign bus.prog_data = prog_data_r;

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Directed bench for cfg_frame_loader.
module tb_cfg_frame_loader;
    logic        clk;
    logic        rst;
    logic        busy;
    logic        err_pulse;
    logic [7:0]  err_cnt;
    logic [15:0] frame_cnt;

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int we_total = 0;
    int err_total = 0;
    int overlap = 0;
    int ready_hi_we = 0;
    int ready_low_other = 0;
    int we_cyc = 0;
    int xfer_cyc = 0;
    logic [3:0]  last_addr = 4'h0;
    logic [33:0] last_data = 34'h0;

    localparam logic [63:0] GOOD = 64'hA5_03_CA_3A_CA_3A_02_01;

    cfg_frame_loader_if #(.ADDR_W(4), .PROG_W(34)) bus ();

    cfg_frame_loader #(.PROG_W(34), .NUM_TILES(16), .SYNC_BYTE(8'hA5)) dut (
        .prog_clk  (clk),
        .prog_res  (rst),
        .bus       (bus),
        .busy      (busy),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.prog_we) begin
            we_total  <= we_total + 1;
            we_cyc    <= cyc;
            last_addr <= bus.prog_addr;
            last_data <= bus.prog_data;
            if (bus.s_ready) ready_hi_we <= ready_hi_we + 1;
            if (err_pulse) overlap <= overlap + 1;
        end
        if (err_pulse) err_total <= err_total + 1;
        if (!bus.s_ready && !bus.prog_we && !err_pulse) ready_low_other <= ready_low_other + 1;
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) tick();
        bus.s_data  = b;
        bus.s_valid = 1'b1;
        n = 0;
        while (bus.s_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL send_timeout byte=%h s_ready stayed %b", b, bus.s_ready);
        end
        xfer_cyc = cyc;
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] f, input int gap);
        for (int i = 7; i >= 0; i--) send_byte(f[i*8 +: 8], gap);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready got=%b exp=1", bus.s_ready); end
        checks++; if (bus.prog_we !== 1'b0) begin errors++; $display("FAIL rst_prog_we got=%b exp=0", bus.prog_we); end
        checks++; if (bus.prog_addr !== 4'h0) begin errors++; $display("FAIL rst_prog_addr got=%h exp=0", bus.prog_addr); end
        checks++; if (bus.prog_data !== 34'h0) begin errors++; $display("FAIL rst_prog_data got=%h exp=0", bus.prog_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL rst_err_pulse got=%b exp=0", err_pulse); end
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL rst_err_cnt got=%h exp=0", err_cnt); end
        checks++; if (frame_cnt !== 16'h0) begin errors++; $display("FAIL rst_frame_cnt got=%h exp=0", frame_cnt); end
    endtask

    task automatic check_good(input string tag, input int we0, input int er0, input int rl0);
        repeat (3) tick();
        checks++; if (we_total - we0 != 1) begin errors++; $display("FAIL %s_we_count got=%0d exp=1", tag, we_total - we0); end
        checks++; if (last_addr !== 4'h3) begin errors++; $display("FAIL %s_addr got=%h exp=3", tag, last_addr); end
        checks++; if (last_data !== 34'h23ACA3ACA) begin errors++; $display("FAIL %s_data got=%h exp=23aca3aca", tag, last_data); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL %s_frame_cnt got=%0d exp=1", tag, frame_cnt); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL %s_err_cnt got=%0d exp=0", tag, err_cnt); end
        checks++; if (err_total - er0 != 0) begin errors++; $display("FAIL %s_err_pulses got=%0d exp=0", tag, err_total - er0); end
        checks++; if (we_cyc - xfer_cyc != 1) begin errors++; $display("FAIL %s_latency got=%0d exp=1", tag, we_cyc - xfer_cyc); end
        checks++; if (ready_low_other - rl0 != 0) begin errors++; $display("FAIL %s_ready_low_outside_commit got=%0d exp=0", tag, ready_low_other - rl0); end
        checks++; if (bus.prog_addr !== 4'h3) begin errors++; $display("FAIL %s_addr_hold got=%h exp=3", tag, bus.prog_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end got=%b exp=0", tag, busy); end
    endtask

    task automatic test_good_frame();
        int we0, er0, rl0;
        do_reset();
        we0 = we_total; er0 = err_total; rl0 = ready_low_other;
        send_byte(8'hA5, 0);
        send_byte(8'h03, 0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL good_busy_mid got=%b exp=1", busy); end
        for (int i = 5; i >= 0; i--) send_byte(GOOD[i*8 +: 8], 0);
        check_good("good", we0, er0, rl0);
    endtask

    task automatic test_pad_error();
        int we0, er0;
        do_reset();
        we0 = we_total; er0 = err_total;
        send_frame(64'hA5_03_CA_3A_CA_3A_06_05, 0);
        repeat (3) tick();
        checks++; if (err_total - er0 != 1) begin errors++; $display("FAIL pad_err_pulses got=%0d exp=1", err_total - er0); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL pad_err_cnt got=%0d exp=1", err_cnt); end
        checks++; if (we_total - we0 != 0) begin errors++; $display("FAIL pad_we_count got=%0d exp=0", we_total - we0); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL pad_frame_cnt got=%0d exp=0", frame_cnt); end
        checks++; if (busy !== 1'b0 || bus.s_ready !== 1'b1) begin errors++; $display("FAIL pad_back_to_sync busy=%b s_ready=%b exp 0/1", busy, bus.s_ready); end
    endtask

    task automatic test_csum_addr_error();
        int we0, er0;
        do_reset();
        we0 = we_total; er0 = err_total;
        send_frame(64'hA5_03_CA_3A_CA_3A_02_00, 0);
        repeat (2) tick();
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL csum_err_cnt got=%0d exp=1", err_cnt); end
        send_frame(64'hA5_10_CA_3A_CA_3A_02_12, 0);
        repeat (2) tick();
        checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL addr_err_cnt got=%0d exp=2", err_cnt); end
        checks++; if (err_total - er0 != 2) begin errors++; $display("FAIL csum_addr_pulses got=%0d exp=2", err_total - er0); end
        checks++; if (we_total - we0 != 0) begin errors++; $display("FAIL csum_addr_we got=%0d exp=0", we_total - we0); end
        checks++; if (overlap != 0) begin errors++; $display("FAIL we_err_overlap got=%0d exp=0", overlap); end
    endtask

    task automatic test_resync();
        int we0, er0, rl0;
        do_reset();
        we0 = we_total; er0 = err_total; rl0 = ready_low_other;
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h5A, 0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL resync_busy got=%b exp=0", busy); end
        send_frame(GOOD, 0);
        check_good("resync", we0, er0, rl0);
    endtask

    task automatic test_gaps();
        int we0, er0, rl0;
        do_reset();
        we0 = we_total; er0 = err_total; rl0 = ready_low_other;
        send_frame(GOOD, 3);
        check_good("gaps", we0, er0, rl0);
        checks++; if (ready_hi_we != 0) begin errors++; $display("FAIL ready_high_in_commit got=%0d exp=0", ready_hi_we); end
    endtask

    task automatic test_reset_mid_frame();
        int we0, er0, rl0;
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h03, 0);
        send_byte(8'hCA, 0);
        send_byte(8'h3A, 0);
        send_byte(8'hCA, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        we0 = we_total; er0 = err_total; rl0 = ready_low_other;
        send_frame(GOOD, 0);
        check_good("midrst", we0, er0, rl0);
    endtask

    initial begin
        rst = 1'b1;
        bus.s_data = 8'h00;
        bus.s_valid = 1'b0;
        test_reset();
        test_good_frame();
        test_pad_error();
        test_csum_addr_error();
        test_resync();
        test_gaps();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
